column_frame_strobe_gen: RTL and testbench
==========================================

# column_frame_strobe_gen

Per-column configuration frame-select stage that drives the `FrameStrobe` bus entering the bottom of a fabric column. The strobe then ripples through each tile's strobe buffers up to the north terminal tile. It accepts frame-address words from the configuration controller over a valid/ready handshake and decodes the column match and frame index. On a valid write to this column it emits a one-hot strobe pulse of fixed length, followed by a mandatory idle gap.

## Interface
Parameters:
- `MaxFramesPerCol`, 20: width of `FrameStrobe`; number of frames per column.
- `FrameSelWidth`, 5: frame-index field width; must satisfy 2^FrameSelWidth >= MaxFramesPerCol.
- `ColSelWidth`, 5: column-select field width.
- `Column`, 0: this column's index; must be below 2^ColSelWidth-1.
- `StrobeCycles`, 2: strobe pulse length in clocks; range 1..15.

Ports:
- `UserCLK`  in  1  sole clock. One clock; reset is synchronous and active-high.
- `reset`  in  1  synchronous, active-high reset.
- `FrameAddr`  in  ColSelWidth+FrameSelWidth  {column[MSBs], frame index[LSBs]}.
- `FrameAddrValid`  in  1  address word valid.
- `FrameAddrReady`  out  1  block can accept a word.
- `FrameStrobe`  out  MaxFramesPerCol  one-hot frame strobe to the column.
- `FrameAddrErr`  out  1  one-cycle pulse when a word addressed to this column has an illegal index.
- `ErrCount`  out  8  saturating illegal-index count (see Configuration).

## Operation
- FSM states:
  - IDLE: `FrameAddrReady`=1, `FrameStrobe`=0.
  - STROBE: exactly one strobe bit high.
  - GAP: everything low, not ready.
- Accept condition: `FrameAddrValid && FrameAddrReady` at a rising edge.
- On accept, classify the word by column field and frame index:
  - Column field == `Column`, or == all-ones (broadcast), and index < MaxFramesPerCol: latch the index, load the cycle counter with StrobeCycles-1, go to STROBE.
  - Column matches, index >= MaxFramesPerCol: word consumed, no strobe. `FrameAddrErr` pulses the next cycle; stay in IDLE.
  - Column mismatch: word consumed silently; stay in IDLE. Other columns' blocks see the same bus.
- STROBE: `FrameStrobe[idx]`=1. Counter decrements each cycle. At 0, go to GAP.
- GAP: one cycle, then return to IDLE.
- `FrameStrobe` is registered. No combinational path from `FrameAddr` to `FrameStrobe`.
- Valid held while not ready: the word is not consumed. The upstream controller must hold `FrameAddr` stable until it is accepted.

## Timing
- Reset values: state IDLE, `FrameAddrReady`=1, `FrameStrobe`=0, `FrameAddrErr`=0, `ErrCount`=0.
- Accept at edge k: `FrameStrobe` is high during cycles k+1 .. k+StrobeCycles.
- GAP occupies cycle k+StrobeCycles+1. `FrameAddrReady` is high again from cycle k+StrobeCycles+2.
- Minimum spacing between back-to-back accepted words is StrobeCycles+2 cycles. Mismatch and illegal words keep ready high, so throughput is one per cycle.
- `FrameAddrErr`: high for exactly cycle k+1 after the offending accept at edge k.
- Reset asserted mid-STROBE or mid-GAP: all outputs reach their reset values at the next edge. There is no partial strobe after that edge.

## Configuration
- Macro `FRAME_STROBE_ERR_CNT_EN`.
- Defined: `ErrCount` increments on each `FrameAddrErr` pulse and saturates at 255. It is cleared only by `reset`.
- Undefined: `ErrCount` is tied to 0 and the counter logic is absent. The port remains, so the interface is unchanged.

## Structure
- Shared package `fabric_cfg_pkg`:
  - FSM state encoding (IDLE=0, STROBE=1, GAP=2).
  - Broadcast-column constant (all-ones).
  - Default widths for `FrameSelWidth` and `ColSelWidth`.
- Sub-module `frame_index_decoder`: registered binary-to-one-hot decoder with an enable input, producing `FrameStrobe`. The FSM and counter stay in the top module.

## Test plan
Parameters for all scenarios: MaxFramesPerCol=20, FrameSelWidth=5, ColSelWidth=5, Column=3, StrobeCycles=2.
- Reset release; FrameAddr={3,7} valid one cycle at edge k -> `FrameStrobe`=0x00080 in cycles k+1 and k+2; ready low k+1..k+3; ready high at k+4.
- FrameAddr={31,19} (broadcast, last frame) -> `FrameStrobe`=0x80000 for 2 cycles; no error.
- FrameAddr={3,25} -> no strobe, `FrameAddrErr` high for 1 cycle, `ErrCount`=1 with macro defined and 0 without; ready stays high.
- FrameAddr={4,7} -> no strobe, no error, ready stays high.
- Valid held continuously with {3,0} then {3,1} -> strobe bit0 for 2 cycles, 1 gap cycle, then bit1 for 2 cycles; each word accepted exactly once.
- Reset asserted in the first STROBE cycle of {3,5} -> `FrameStrobe`=0 and ready=1 at the next edge; no further strobe.

Source files
------------

// File: rtl/fabric_cfg_pkg.sv
// Shared fabric configuration definitions: frame-strobe FSM encoding,
// the broadcast column code and default address field widths.
package fabric_cfg_pkg;

    // Frame-strobe sequencer states. Encoding is fixed so that debug
    // probes and checkers can decode the raw value.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_GAP    = 2'd2
    } strobe_state_e;

    // Default widths of the {column, frame index} address fields.
    localparam int DefaultFrameSelWidth = 5;
    localparam int DefaultColSelWidth   = 5;

    // A column field of all ones addresses every column at once.
    // The user slices this to the column field width.
    localparam logic [31:0] BroadcastColAll = '1;

    // Width of the strobe-length counter (StrobeCycles range 1..15).
    localparam int StrobeCntWidth = 4;

endpackage

// File: rtl/column_frame_strobe_gen_if.sv
// Frame-address handshake between the configuration controller (master)
// and a column frame-strobe stage (slave).
//
// Handshake: a word transfers on a rising edge where FrameAddrValid and
// FrameAddrReady are both high. While valid is high and ready is low the
// master must hold FrameAddr stable and keep valid asserted; ready may
// depend only on the slave's registered state, never on valid.
//
// state_dbg exposes the slave's sequencer state for probing.
interface column_frame_strobe_gen_if
    import fabric_cfg_pkg::*;
#(
    parameter int AddrWidth = DefaultColSelWidth + DefaultFrameSelWidth
) ();

    logic [AddrWidth-1:0] FrameAddr;
    logic                 FrameAddrValid;
    logic                 FrameAddrReady;
    strobe_state_e        state_dbg;

    modport master (
        output FrameAddr,
        output FrameAddrValid,
        input  FrameAddrReady,
        input  state_dbg
    );

    modport slave (
        input  FrameAddr,
        input  FrameAddrValid,
        output FrameAddrReady,
        output state_dbg
    );

endinterface

// File: rtl/frame_index_decoder.sv
// Registered binary-to-one-hot decoder. When en is high the bit selected
// by sel is set on the next edge; otherwise the output clears. The
// caller guarantees sel < Width whenever en is high.
module frame_index_decoder #(
    parameter int Width    = 20,
    parameter int SelWidth = 5
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SelWidth-1:0] sel,
    output logic [Width-1:0]    strobe
);

    logic [Width-1:0] strobe_d;
    logic [Width-1:0] strobe_q;

    // Next one-hot pattern: only the selected bit, and only when enabled.
    always_comb begin
        strobe_d = '0;
        for (int i = 0; i < Width; i++) begin
            strobe_d[i] = en && (sel == SelWidth'(i));
        end
    end

    // Output register; reset clears any strobe in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q <= '0;
        end else begin
            strobe_q <= strobe_d;
        end
    end

    assign strobe = strobe_q;

endmodule

// File: rtl/column_frame_strobe_gen.sv
// Column frame-select stage. Accepts {column, frame index} words from the
// configuration controller and, for words addressed to this column (or
// broadcast) with a legal index, drives a one-hot FrameStrobe pulse of
// StrobeCycles clocks followed by one idle gap clock. Words for other
// columns are consumed silently; words for this column with an index
// beyond the column's frame count raise a one-cycle FrameAddrErr.
//
// Optional feature macro: FRAME_STROBE_ERR_CNT_EN
//   defined   - ErrCount counts FrameAddrErr pulses, saturating at 255.
//   undefined - ErrCount is tied to zero and no counter is built.
module column_frame_strobe_gen
    import fabric_cfg_pkg::*;
#(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameSelWidth   = DefaultFrameSelWidth,
    parameter int ColSelWidth     = DefaultColSelWidth,
    parameter int Column          = 0,
    parameter int StrobeCycles    = 2
) (
    input  logic                        UserCLK,
    input  logic                        reset,
    column_frame_strobe_gen_if.slave    addr_if,
    output logic [MaxFramesPerCol-1:0]  FrameStrobe,
    output logic                        FrameAddrErr,
    output logic [7:0]                  ErrCount
);

    localparam int AddrWidth = ColSelWidth + FrameSelWidth;

    localparam logic [ColSelWidth-1:0]    OwnCol     = ColSelWidth'(Column);
    localparam logic [ColSelWidth-1:0]    BcastCol   = BroadcastColAll[ColSelWidth-1:0];
    // One extra bit so a frame count equal to 2^FrameSelWidth still fits.
    localparam logic [FrameSelWidth:0]    FrameLimit = (FrameSelWidth + 1)'(MaxFramesPerCol);
    localparam logic [StrobeCntWidth-1:0] CntLoad    = StrobeCntWidth'(StrobeCycles - 1);

    // Address word fields.
    logic [ColSelWidth-1:0]   addr_col;
    logic [FrameSelWidth-1:0] addr_idx;
    logic                     col_hit;
    logic                     idx_legal;
    logic                     ready;
    logic                     accept;

    // Sequencer state.
    strobe_state_e             state_d, state_q;
    logic [StrobeCntWidth-1:0] cnt_d, cnt_q;
    logic [FrameSelWidth-1:0]  idx_d, idx_q;
    logic                      err_d, err_q;

    // Decoder control.
    logic                      dec_en;
    logic [FrameSelWidth-1:0]  dec_idx;

    assign addr_col  = addr_if.FrameAddr[AddrWidth-1 -: ColSelWidth];
    assign addr_idx  = addr_if.FrameAddr[FrameSelWidth-1:0];
    assign col_hit   = (addr_col == OwnCol) || (addr_col == BcastCol);
    assign idx_legal = ({1'b0, addr_idx} < FrameLimit);

    // Ready comes straight from registered state, so valid never loops
    // back into ready within a cycle.
    assign ready  = (state_q == ST_IDLE);
    assign accept = addr_if.FrameAddrValid && ready;

    assign addr_if.FrameAddrReady = ready;
    assign addr_if.state_dbg      = state_q;

    // Next-state, counter and decoder-enable logic. The decoder is asked
    // for a strobe on every edge that leads into (or stays in) STROBE, so
    // the registered strobe lines up exactly with the STROBE state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = 1'b0;
        dec_en  = 1'b0;
        dec_idx = idx_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept && col_hit) begin
                    if (idx_legal) begin
                        state_d = ST_STROBE;
                        cnt_d   = CntLoad;
                        idx_d   = addr_idx;
                        dec_en  = 1'b1;
                        dec_idx = addr_idx;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d = ST_GAP;
                end else begin
                    cnt_d  = cnt_q - 1'b1;
                    dec_en = 1'b1;
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sequencer registers.
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
        end
    end

    assign FrameAddrErr = err_q;

    frame_index_decoder #(
        .Width    (MaxFramesPerCol),
        .SelWidth (FrameSelWidth)
    ) u_frame_index_decoder (
        .clk    (UserCLK),
        .rst    (reset),
        .en     (dec_en),
        .sel    (dec_idx),
        .strobe (FrameStrobe)
    );

`ifdef FRAME_STROBE_ERR_CNT_EN
    logic [7:0] err_cnt_d, err_cnt_q;

    // Count each illegal-index word, holding at 255 once reached. The
    // count moves on the same edge that raises FrameAddrErr.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (err_d && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Error counter register; cleared only by reset.
    always_ff @(posedge UserCLK) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ErrCount = err_cnt_q;
`else
    assign ErrCount = '0;
`endif

endmodule

// File: tb/tb_column_frame_strobe_gen.sv
// Bench for column_frame_strobe_gen (Column=3, 20 frames, 2-cycle strobe).
// A timestamp model predicts every output from the accept edges; directed
// scenarios add literal expectations at chosen cycles.
module tb_column_frame_strobe_gen;
    import fabric_cfg_pkg::*;

    localparam int MaxFrames = 20;
    localparam int Fsw       = 5;
    localparam int Csw       = 5;
    localparam int ColIdx    = 3;
    localparam int S         = 2;
    localparam int Aw        = Csw + Fsw;

`ifdef FRAME_STROBE_ERR_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    column_frame_strobe_gen_if #(.AddrWidth(Aw)) bus ();

    logic [MaxFrames-1:0] strobe;
    logic                 err;
    logic [7:0]           err_cnt;

    column_frame_strobe_gen #(
        .MaxFramesPerCol (MaxFrames),
        .FrameSelWidth   (Fsw),
        .ColSelWidth     (Csw),
        .Column          (ColIdx),
        .StrobeCycles    (S)
    ) dut (
        .UserCLK      (clk),
        .reset        (rst),
        .addr_if      (bus),
        .FrameStrobe  (strobe),
        .FrameAddrErr (err),
        .ErrCount     (err_cnt)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [Aw-1:0] mk(input int c, input int i);
        logic [Csw-1:0] cf;
        logic [Fsw-1:0] xf;
        cf = c[Csw-1:0];
        xf = i[Fsw-1:0];
        return {cf, xf};
    endfunction

    // ---------------- model ----------------
    // cyc counts rising edges. acc_m is the edge of the last accepted
    // strobing word: strobe lasts for the S periods after edges acc_m ..
    // acc_m+S-1, the gap is the period after acc_m+S, and the block is
    // ready again after edge acc_m+S+1. err_edge_m is the edge that took
    // the last illegal word; the error pulse is the period after it.
    int cyc        = 0;
    int acc_m      = -1000;
    int idx_m      = 0;
    int err_edge_m = -1000;
    int err_cnt_m  = 0;
    bit seen_rst   = 1'b0;

    initial begin
        int c;
        int i;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                acc_m      = -1000;
                err_edge_m = -1000;
                err_cnt_m  = 0;
                seen_rst   = 1'b1;
            end else if (bus.FrameAddrValid === 1'b1 && (cyc - 1) > acc_m + S) begin
                c = int'(bus.FrameAddr[Aw-1:Fsw]);
                i = int'(bus.FrameAddr[Fsw-1:0]);
                if (c == ColIdx || c == (1 << Csw) - 1) begin
                    if (i < MaxFrames) begin
                        acc_m = cyc;
                        idx_m = i;
                    end else begin
                        err_edge_m = cyc;
                        if (err_cnt_m < 255) err_cnt_m++;
                    end
                end
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    initial begin
        logic [MaxFrames-1:0] exp_s;
        logic                 exp_r;
        logic                 exp_e;
        int                   c;
        forever begin
            @(negedge clk);
            if (seen_rst) begin
                c     = cyc;
                exp_s = (c >= acc_m && c <= acc_m + S - 1) ? (MaxFrames'(1) << idx_m) : '0;
                exp_r = (c > acc_m + S);
                exp_e = (c == err_edge_m);
                check("model_strobe", strobe, exp_s);
                check("model_ready", bus.FrameAddrReady, exp_r);
                check("model_err", err, exp_e);
                check("model_errcnt", err_cnt, CntEn ? err_cnt_m : 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called on a falling edge with the DUT ready; returns on the falling
    // edge just after the accepting rising edge.
    task automatic send_one(input int c, input int i);
        bus.FrameAddr      = mk(c, i);
        bus.FrameAddrValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.FrameAddrValid = 1'b0;
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (bus.FrameAddrReady !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("wait_ready", bus.FrameAddrReady, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: no finish by time limit");
        $fatal(1, "timeout");
    end

    // ---------------- directed stimulus ----------------
    initial begin
        bus.FrameAddr      = '0;
        bus.FrameAddrValid = 1'b0;
        rst                = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_strobe", strobe, 0);
        check("rst_ready", bus.FrameAddrReady, 1);
        check("rst_err", err, 0);
        check("rst_errcnt", err_cnt, 0);
        check("rst_state", bus.state_dbg, 0);
        rst = 1'b0;
        @(negedge clk);

        // {3,7}: bit 7 for two cycles, gap, ready again on the fourth.
        send_one(3, 7);
        check("s1_strobe_k1", strobe, 32'h00080);
        check("s1_ready_k1", bus.FrameAddrReady, 0);
        check("s1_state_k1", bus.state_dbg, 1);
        @(negedge clk);
        check("s1_strobe_k2", strobe, 32'h00080);
        check("s1_ready_k2", bus.FrameAddrReady, 0);
        @(negedge clk);
        check("s1_strobe_k3", strobe, 0);
        check("s1_ready_k3", bus.FrameAddrReady, 0);
        check("s1_state_gap", bus.state_dbg, 2);
        @(negedge clk);
        check("s1_ready_k4", bus.FrameAddrReady, 1);

        // Broadcast to the last frame.
        send_one(31, 19);
        check("s2_strobe_k1", strobe, 32'h80000);
        check("s2_err_k1", err, 0);
        @(negedge clk);
        check("s2_strobe_k2", strobe, 32'h80000);
        wait_ready(8);

        // Own column, illegal index.
        send_one(3, 25);
        check("s3_strobe", strobe, 0);
        check("s3_err_k1", err, 1);
        check("s3_ready", bus.FrameAddrReady, 1);
        check("s3_errcnt", err_cnt, CntEn ? 1 : 0);
        @(negedge clk);
        check("s3_err_k2", err, 0);

        // Other column: silently consumed.
        send_one(4, 7);
        check("s4_strobe", strobe, 0);
        check("s4_err", err, 0);
        check("s4_ready", bus.FrameAddrReady, 1);

        // Valid held across two words.
        bus.FrameAddr      = mk(3, 0);
        bus.FrameAddrValid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("s5_w0_c1", strobe, 32'h1);
        check("s5_ready_c1", bus.FrameAddrReady, 0);
        bus.FrameAddr = mk(3, 1);
        @(negedge clk);
        check("s5_w0_c2", strobe, 32'h1);
        @(negedge clk);
        check("s5_gap", strobe, 0);
        check("s5_gap_ready", bus.FrameAddrReady, 0);
        @(negedge clk);
        check("s5_ready", bus.FrameAddrReady, 1);
        @(negedge clk);
        check("s5_w1_c1", strobe, 32'h2);
        bus.FrameAddrValid = 1'b0;
        @(negedge clk);
        check("s5_w1_c2", strobe, 32'h2);
        @(negedge clk);
        check("s5_gap2", strobe, 0);
        @(negedge clk);
        check("s5_end_strobe", strobe, 0);
        check("s5_end_ready", bus.FrameAddrReady, 1);

        // Reset in the first strobe cycle of {3,5}.
        send_one(3, 5);
        check("s6_strobe_k1", strobe, 32'h20);
        rst = 1'b1;
        @(negedge clk);
        check("s6_rst_strobe", strobe, 0);
        check("s6_rst_ready", bus.FrameAddrReady, 1);
        check("s6_rst_errcnt", err_cnt, 0);
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check("s6_no_strobe", strobe, 0);
        end

        // One word per cycle: mismatch, then three illegal indices.
        bus.FrameAddrValid = 1'b1;
        bus.FrameAddr      = mk(4, 1);
        @(negedge clk);
        check("s7_ready_a", bus.FrameAddrReady, 1);
        bus.FrameAddr = mk(3, 20);
        @(negedge clk);
        check("s7_err_a", err, 1);
        bus.FrameAddr = mk(31, 30);
        @(negedge clk);
        check("s7_err_b", err, 1);
        bus.FrameAddr = mk(3, 31);
        @(negedge clk);
        bus.FrameAddrValid = 1'b0;
        @(negedge clk);
        check("s7_errcnt", err_cnt, CntEn ? 3 : 0);
        check("s7_ready_end", bus.FrameAddrReady, 1);
        send_one(31, 0);
        check("s7_bcast0", strobe, 32'h1);
        wait_ready(8);

        // Saturation: 260 illegal words back to back.
        bus.FrameAddr      = mk(3, 24);
        bus.FrameAddrValid = 1'b1;
        repeat (260) @(negedge clk);
        bus.FrameAddrValid = 1'b0;
        @(negedge clk);
        check("s8_errcnt_sat", err_cnt, CntEn ? 255 : 0);

        repeat (4) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
